// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the core's single valid/ready memory port.
// Fetch vs load/store, data priority with a starvation guard, plus a bus watchdog.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic        err_src,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);
    localparam logic [15:0] TMO   = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        err_src_q, err_src_nxt;
    logic        is_d, gnt_valid, done, timeout;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            err_src_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
            err_src_q  <= err_src_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        wait_nxt    = wait_cnt;
        err_src_nxt = err_src_q;
        is_d        = 1'b0;
        gnt_valid   = 1'b0;
        done        = 1'b0;
        timeout     = 1'b0;
        i_ready     = 1'b0;
        i_rdata     = '0;
        d_ready     = 1'b0;
        d_rdata     = '0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        err         = 1'b0;
        err_src     = 1'b0;
        busy        = 1'b0;

        // Outputs are forced low for the whole reset cycle, combinational ones included.
        if (rstn) begin
            busy    = (state != IDLE);
            err_src = err_src_q;
            case (state)
                IDLE: begin
                    wait_nxt = '0;
                    if (d_valid && !(i_valid && starve_cnt == LIMIT)) begin
                        state_nxt = GNT_D;
                        if (i_valid) starve_nxt = starve_cnt + 4'd1;
                    end else if (i_valid) begin
                        state_nxt  = GNT_I;
                        starve_nxt = '0;
                    end
                end
                GNT_I, GNT_D: begin
                    is_d      = (state == GNT_D);
                    gnt_valid = is_d ? d_valid : i_valid;
                    mem_valid = gnt_valid;
                    mem_addr  = is_d ? d_addr : i_addr;
                    mem_wdata = is_d ? d_wdata : '0;
                    mem_wstrb = is_d ? d_wstrb : 4'b0000;
                    done      = gnt_valid && mem_ready;
                    // mem_ready on the timeout cycle wins, so timeout needs it low.
                    timeout   = gnt_valid && !mem_ready && (TMO != 16'd0) && (wait_cnt == TMO);
                    if (done || timeout) begin
                        if (is_d) begin
                            d_ready = 1'b1;
                            d_rdata = done ? mem_rdata : '0;
                        end else begin
                            i_ready = 1'b1;
                            i_rdata = done ? mem_rdata : '0;
                        end
                    end
                    if (timeout) begin
                        err         = 1'b1;
                        err_src     = is_d;
                        err_src_nxt = is_d;
                    end
                    if (!gnt_valid || done || timeout) state_nxt = IDLE;
                    else wait_nxt = wait_cnt + 16'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
